// File: rtl/mem_arbiter.sv
// Shares one unified RAM port between instruction fetch and data access.
// A data access is always served before a fetch raised in the same pipeline cycle.
module mem_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        cpu_rst_n,
   input  logic        inst_ren,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_data,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        stall,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      D_ACC,
      I_ACC
   } state_t;

   state_t        state;
   logic          d_done;
   logic          i_done;
   logic [CW-1:0] wait_cnt;

   logic pend_d;
   logic pend_i;
   logic acc_end;

   assign pend_d  = (mem_ren | mem_wen) & ~d_done;
   assign pend_i  = inst_ren & ~i_done;
   assign stall   = pend_d | pend_i | (state != IDLE);
   // An access ends either on ack or when its last permitted wait cycle passes without one.
   assign acc_end = ram_ack | (wait_cnt == LAST_WAIT);

   // Arbiter FSM with registered RAM-side outputs and result registers.
   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state     <= IDLE;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         inst_data <= '0;
         mem_din   <= '0;
         d_done    <= 1'b0;
         i_done    <= 1'b0;
         wait_cnt  <= '0;
         bus_err   <= 1'b0;
      end else begin
         if (!stall) begin
            d_done <= 1'b0;
            i_done <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (pend_d) begin
                  state     <= D_ACC;
                  ram_req   <= 1'b1;
                  ram_addr  <= mem_addr;
                  ram_wdata <= mem_dout;
                  ram_we    <= mem_wen;
                  wait_cnt  <= '0;
               end else if (pend_i) begin
                  state    <= I_ACC;
                  ram_req  <= 1'b1;
                  ram_addr <= inst_addr;
                  ram_we   <= 1'b0;
                  wait_cnt <= '0;
               end
            end
            D_ACC: begin
               if (acc_end) begin
                  if (!ram_we) begin
                     mem_din <= ram_ack ? ram_rdata : 32'hFFFF_FFFF;
                  end
                  if (!ram_ack) begin
                     bus_err <= 1'b1;
                  end
                  d_done <= 1'b1;
                  // A fetch waiting behind the data beat starts without returning to IDLE.
                  if (pend_i) begin
                     state    <= I_ACC;
                     ram_addr <= inst_addr;
                     ram_we   <= 1'b0;
                     wait_cnt <= '0;
                  end else begin
                     state   <= IDLE;
                     ram_req <= 1'b0;
                     ram_we  <= 1'b0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            I_ACC: begin
               if (acc_end) begin
                  inst_data <= ram_ack ? ram_rdata : 32'hFFFF_FFFF;
                  if (!ram_ack) begin
                     bus_err <= 1'b1;
                  end
                  i_done  <= 1'b1;
                  state   <= IDLE;
                  ram_req <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               ram_req <= 1'b0;
               ram_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles one access waits for ram_ack before it is aborted.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: cpu_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: inst_ren  input  1  fetch request from IF stage.
REQ-005 Port: inst_addr  input  32  fetch address.
REQ-006 Port: inst_data  output  32  registered fetched instruction.
REQ-007 Port: mem_ren / mem_wen  input  1 each  data read/write request from MEM stage.
REQ-008 Port: mem_addr  input  32  data address.
REQ-009 Port: mem_dout  input  32  store data from datapath.
REQ-010 Port: mem_din  output  32  registered load data to datapath.
REQ-011 Port: stall  output  1  pipeline hold; top level drives datapath cpu_en = cpu_en & ~stall.
REQ-012 Port: ram_req, ram_we  output  1 each  unified memory request and write strobe.
REQ-013 Port: ram_addr, ram_wdata  output  32 each  unified memory address and write data.
REQ-014 Port: ram_rdata  input  32; ram_ack  input  1  read data and completion, sampled while ram_req=1.
REQ-015 Port: bus_err  output  1  sticky timeout flag.

Function
REQ-016 Internal flags d_done and i_done mark requests already served in the current pipeline cycle.
REQ-017 pend_d = (mem_ren|mem_wen) & ~d_done; pend_i = inst_ren & ~i_done; stall = pend_d | pend_i | (state != IDLE), combinational.
REQ-018 FSM states: IDLE, D_ACC, I_ACC; ram_req=1 exactly in D_ACC and I_ACC (Moore).
REQ-019 IDLE: pend_d -> D_ACC; else pend_i -> I_ACC; else stay. Data beats fetch (older instruction first).
REQ-020 On entry to D_ACC: latch ram_addr=mem_addr, ram_wdata=mem_dout, ram_we=mem_wen; mem_wen with mem_ren both set is a write.
REQ-021 On entry to I_ACC: latch ram_addr=inst_addr, ram_we=0; ram_wdata unchanged.
REQ-022 ram_addr/ram_we/ram_wdata remain constant for the whole access regardless of input changes.
REQ-023 D_ACC with ram_ack: if read, mem_din<=ram_rdata; d_done<=1; next I_ACC if pend_i else IDLE.
REQ-024 I_ACC with ram_ack: inst_data<=ram_rdata; i_done<=1; next IDLE.
REQ-025 Per-access wait counter cleared at access entry; counts cycles in D_ACC/I_ACC without ack.
REQ-026 Counter reaching TIMEOUT without ack: abort, bus_err<=1, destination register (mem_din for reads, inst_data for fetches) <=32'hFFFF_FFFF, done flag set, transition as if acked.
REQ-027 ram_ack sampled outside D_ACC/I_ACC is ignored.
REQ-028 At any rising edge with stall=0, d_done and i_done clear to 0 (pipeline advanced).
REQ-029 mem_din and inst_data hold value until overwritten by a later completed access.
REQ-030 Minimum latency with ack in first request cycle: 2 stall cycles for single access, 3 for fetch+data.
REQ-031 bus_err cleared only by reset.

Reset
REQ-032 cpu_rst_n=0 asynchronously forces: state IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, inst_data=0, mem_din=0, d_done=i_done=0, counter=0, bus_err=0.
REQ-033 Reset mid-access drops ram_req immediately; the aborted access is never completed or retried.
REQ-034 After cpu_rst_n rises, first request accepted at the next rising edge.

Verification
REQ-035 Fetch only, inst_addr=0x10, ack in first req cycle, rdata=0x2002_0005 -> stall high 2 cycles, inst_data=0x2002_0005, ram_we=0.
REQ-036 Fetch 0x14 and load 0x80 same cycle -> D_ACC (ram_addr=0x80) precedes I_ACC (ram_addr=0x14), stall 3 cycles, both outputs correct.
REQ-037 mem_ren=mem_wen=1, addr 0x40, dout 0xDEAD_BEEF -> ram_we=1, ram_wdata=0xDEAD_BEEF, mem_din unchanged.
REQ-038 No ack, TIMEOUT=16 -> abort after 16 wait cycles, bus_err=1, mem_din=0xFFFF_FFFF, stall releases.
REQ-039 cpu_rst_n low during D_ACC with ram_addr=0x80 -> ram_req=0 same cycle, all outputs 0, no completion after release.
REQ-040 Back-to-back requests with stall=0 between -> done flags clear, second pipeline cycle re-arbitrates, no request lost or duplicated.
